// File: rtl/fir_filter.sv
// fir_filter: 8-tap direct-form FIR with fixed signed coefficients.
// A sample is taken on every clock. Products and an adder tree are
// registered, so a result reaches y_out 4 clocks after its sample.
// All sums are 32-bit two's complement and wrap; nothing saturates.
module fir_filter #(
  parameter logic signed [15:0] COEF0 = 16'sd1,
  parameter logic signed [15:0] COEF1 = 16'sd2,
  parameter logic signed [15:0] COEF2 = 16'sd3,
  parameter logic signed [15:0] COEF3 = 16'sd4,
  parameter logic signed [15:0] COEF4 = 16'sd4,
  parameter logic signed [15:0] COEF5 = 16'sd3,
  parameter logic signed [15:0] COEF6 = 16'sd2,
  parameter logic signed [15:0] COEF7 = 16'sd1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] x_in,
  output logic signed [31:0] y_out
);

  localparam logic signed [15:0] coef [8] = '{COEF0, COEF1, COEF2, COEF3,
                                              COEF4, COEF5, COEF6, COEF7};

  logic signed [15:0] d  [8];
  logic signed [31:0] p  [8];
  logic signed [31:0] s2 [4];
  logic signed [31:0] s3 [2];

  // Delay line: d[0] holds the newest sample, d[7] the oldest.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) d[i] <= '0;
    end else begin
      d[0] <= x_in;
      for (int i = 1; i < 8; i++) d[i] <= d[i-1];
    end
  end

  // Stage 1: full-precision signed products, operands sign-extended to 32 bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) p[i] <= '0;
    end else begin
      for (int i = 0; i < 8; i++) p[i] <= 32'(d[i]) * 32'(coef[i]);
    end
  end

  // Stage 2: pairwise sums of neighbouring products.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int j = 0; j < 4; j++) s2[j] <= '0;
    end else begin
      for (int j = 0; j < 4; j++) s2[j] <= p[2*j] + p[2*j+1];
    end
  end

  // Stage 3: pairwise sums of the stage-2 results.
  always_ff @(posedge clk) begin
    if (reset) begin
      s3[0] <= '0;
      s3[1] <= '0;
    end else begin
      s3[0] <= s2[0] + s2[1];
      s3[1] <= s2[2] + s2[3];
    end
  end

  // Stage 4: final wrap-around sum drives the registered output.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_out <= '0;
    end else begin
      y_out <= s3[0] + s3[1];
    end
  end

endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: directed and random checks of fir_filter against a
// sample-history model (sum of coefficient times delayed sample, mod 2^32).
module tb_fir_filter;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic signed [15:0] x_in = '0;
  logic signed [31:0] y_def;
  logic signed [31:0] y_wrap;

  int errors = 0;
  int checks = 0;

  // Samples captured since the last reset, oldest first.
  int xs[$];
  int defCoef[8] = '{1, 2, 3, 4, 4, 3, 2, 1};
  int rampExp[9] = '{1, 4, 10, 20, 34, 51, 70, 90, 101};
  int impExp[8]  = '{1, 2, 3, 4, 4, 3, 2, 1};

  fir_filter dut_def (
    .clk   (clk),
    .reset (reset),
    .x_in  (x_in),
    .y_out (y_def)
  );

  fir_filter #(
    .COEF0(16'sh8000), .COEF1(16'sh8000), .COEF2(16'sh8000), .COEF3(16'sh8000),
    .COEF4(16'sh8000), .COEF5(16'sh8000), .COEF6(16'sh8000), .COEF7(16'sh8000)
  ) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .x_in  (x_in),
    .y_out (y_wrap)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // Expected output right now: the output shows the sample captured 4 edges ago.
  function automatic logic [31:0] modelOut(input bit allNeg);
    longint acc;
    int k;
    acc = 0;
    k = xs.size() - 5;
    for (int i = 0; i < 8; i++) begin
      if (k - i >= 0)
        acc += longint'(allNeg ? -32768 : defCoef[i]) * longint'(xs[k-i]);
    end
    return acc[31:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d (0x%08h) expected=%0d (0x%08h)",
             tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // Drive one clock of input, update the model, then check both filters.
  task automatic applyStimulus(input int xv, input bit r);
    x_in  = 16'(xv);
    reset = r;
    @(posedge clk);
    if (r) xs.delete();
    else   xs.push_back(int'(x_in));
    #1;
    checkOutput("model_def", y_def, modelOut(1'b0));
    checkOutput("model_wrap", y_wrap, modelOut(1'b1));
  endtask

  initial begin
    // Reset state.
    applyStimulus(0, 1'b1);
    applyStimulus(0, 1'b1);
    checkOutput("reset_y", y_def, 32'd0);

    // Ramp 1..8 then zeros; edge e counts from the first captured sample.
    for (int e = 0; e < 20; e++) begin
      applyStimulus((e < 8) ? e + 1 : 0, 1'b0);
      if (e < 4)              checkOutput("ramp_fill", y_def, 32'd0);
      if (e >= 4 && e <= 12)  checkOutput("ramp_value", y_def, 32'(rampExp[e-4]));
      if (e == 19)            checkOutput("ramp_decay", y_def, 32'd0);
    end

    // Mid-stream reset discards in-flight results and restarts history.
    applyStimulus(0, 1'b1);
    for (int e = 0; e < 6; e++) applyStimulus(e + 1, 1'b0);
    applyStimulus(7, 1'b1);
    checkOutput("midreset_zero", y_def, 32'd0);
    for (int e = 0; e < 14; e++) begin
      applyStimulus((e < 8) ? e + 1 : 0, 1'b0);
      if (e < 4)             checkOutput("midreset_fill", y_def, 32'd0);
      if (e >= 4 && e <= 12) checkOutput("midreset_ramp", y_def, 32'(rampExp[e-4]));
    end

    // Impulse response and exact 4-clock latency.
    applyStimulus(0, 1'b1);
    for (int e = 0; e < 14; e++) begin
      applyStimulus((e == 0) ? 1 : 0, 1'b0);
      if (e == 3)            checkOutput("latency_before", y_def, 32'd0);
      if (e >= 4 && e <= 11) checkOutput("impulse", y_def, 32'(impExp[e-4]));
      if (e > 11)            checkOutput("impulse_tail", y_def, 32'd0);
    end

    // Negative full scale: default settles to -655360, all -32768 taps wrap to 0.
    applyStimulus(0, 1'b1);
    for (int e = 0; e < 14; e++) begin
      applyStimulus(-32768, 1'b0);
      if (e >= 11) begin
        checkOutput("negfull", y_def, 32'hFFF6_0000);
        checkOutput("wrap", y_wrap, 32'd0);
      end
    end

    // Random samples with occasional resets.
    applyStimulus(0, 1'b1);
    for (int n = 0; n < 300; n++) begin
      applyStimulus(int'($urandom_range(0, 65535)), ($urandom_range(0, 31) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
